// File: rtl/seg_scan_decoder.sv
// Scanned 4-digit 7-segment bus decoder: samples a multiplexed LED bus, debounces each
// digit position and publishes complete BCD frames with error and idle reporting.
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] led_seg,
  input  logic       a1,
  input  logic       a2,
  input  logic       a3,
  input  logic       a4,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] blank,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       idle
);

  localparam logic [3:0]  STABLE  = 4'(STABLE_CYC);
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYC);

  // Decoded segment pattern: {valid, blank, bcd}; invalid patterns yield digit 0, not blank.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = {2'b10, 4'd0};
      7'b1111001: decode = {2'b10, 4'd1};
      7'b0100100: decode = {2'b10, 4'd2};
      7'b0110000: decode = {2'b10, 4'd3};
      7'b0011001: decode = {2'b10, 4'd4};
      7'b0010010: decode = {2'b10, 4'd5};
      7'b0000010: decode = {2'b10, 4'd6};
      7'b1111000: decode = {2'b10, 4'd7};
      7'b0000000: decode = {2'b10, 4'd8};
      7'b0010000: decode = {2'b10, 4'd9};
      7'b1111111: decode = {2'b11, 4'd0};
      default:    decode = {2'b00, 4'd0};
    endcase
  endfunction

  // Anode vectors are {a4,a3,a2,a1}, so bit i is digit position i+1.
  logic [6:0]  seg_q, seg_p;
  logic [3:0]  an_q, an_p;
  logic [3:0]  stab_cnt, stab_cnt_d;
  logic        run_done, run_done_d;
  logic [15:0] idle_cnt, idle_cnt_d;
  logic [3:0]  seen, seen_d;
  logic        pend_err, pend_err_d;
  logic        coll_flag, coll_flag_d;
  logic [3:0]  sh_dig [4];
  logic [3:0]  sh_blank;

  logic [3:0]  lows;
  logic        active, collision, same, accept, publish, idle_hit;
  logic [1:0]  pos;
  logic [5:0]  dec;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pos        = 2'd0;
    lows       = ~an_q;
    collision  = (lows & (lows - 4'd1)) != 4'd0;
    active     = (lows != 4'd0) && !collision;
    same       = (seg_q == seg_p) && (an_q == an_p);
    dec        = decode(seg_q);
    publish    = &seen;

    case (lows)
      4'b0010: pos = 2'd1;
      4'b0100: pos = 2'd2;
      4'b1000: pos = 2'd3;
      default: pos = 2'd0;
    endcase

    if (collision)             stab_cnt_d = 4'd0;
    else if (!same)            stab_cnt_d = 4'd1;
    else if (stab_cnt == 4'hF) stab_cnt_d = 4'hF;
    else                       stab_cnt_d = stab_cnt + 4'd1;

    // run_done limits acceptance to once per stable run, independent of counter saturation.
    accept     = active && (stab_cnt_d >= STABLE) && !(same && run_done);
    run_done_d = (same && run_done) || accept;

    if (active)                  idle_cnt_d = 16'd0;
    else if (idle_cnt == TIMEOUT) idle_cnt_d = TIMEOUT;
    else                         idle_cnt_d = idle_cnt + 16'd1;
    idle_hit = !active && (idle_cnt != TIMEOUT) && (idle_cnt_d == TIMEOUT);

    seen_d      = (publish || idle_hit) ? 4'd0 : seen;
    pend_err_d  = (publish || idle_hit) ? 1'b0 : pend_err;
    coll_flag_d = (publish || idle_hit) ? 1'b0 : coll_flag;
    if (accept) begin
      seen_d[pos] = 1'b1;
      if (!dec[5]) pend_err_d = 1'b1;
    end
    if (collision) coll_flag_d = 1'b1;

    idle = (idle_cnt == TIMEOUT) && !active;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q       <= 7'h7F;
      seg_p       <= 7'h7F;
      an_q        <= 4'hF;
      an_p        <= 4'hF;
      stab_cnt    <= 4'd0;
      run_done    <= 1'b0;
      idle_cnt    <= 16'd0;
      seen        <= 4'd0;
      pend_err    <= 1'b0;
      coll_flag   <= 1'b0;
      // NOTE: the shadow array is reset on purpose so no partial frame can survive a reset.
      for (int i = 0; i < 4; i++) sh_dig[i] <= 4'd0;
      sh_blank    <= 4'd0;
      dig1        <= 4'd0;
      dig2        <= 4'd0;
      dig3        <= 4'd0;
      dig4        <= 4'd0;
      blank       <= 4'b1111;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
    end else begin
      seg_q       <= led_seg;
      an_q        <= {a4, a3, a2, a1};
      seg_p       <= seg_q;
      an_p        <= an_q;
      stab_cnt    <= stab_cnt_d;
      run_done    <= run_done_d;
      idle_cnt    <= idle_cnt_d;
      seen        <= seen_d;
      pend_err    <= pend_err_d;
      coll_flag   <= coll_flag_d;
      frame_valid <= publish;

      if (accept) begin
        sh_dig[pos]   <= dec[3:0];
        sh_blank[pos] <= dec[4];
      end

      // Publishing copies the registered shadow, so an acceptance in this cycle joins the next frame.
      if (publish) begin
        dig1    <= sh_dig[0];
        dig2    <= sh_dig[1];
        dig3    <= sh_dig[2];
        dig4    <= sh_dig[3];
        blank   <= sh_blank;
        seg_err <= pend_err || coll_flag;
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYC, default 2: consecutive identical samples required before a digit is accepted; legal range 1-15.
REQ-002 Parameter TIMEOUT_CYC, default 1024: cycles with no anode active before `idle` asserts; legal range 2-65535.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
REQ-005 led_seg  input  7  segment bus, active-low; bit0=a ... bit6=g.
REQ-006 a1, a2, a3, a4  input  1 each  digit anodes, active-low; a1 is the most significant digit and a4 the least.
REQ-007 dig1..dig4  output  4 each  last published BCD digit per position.
REQ-008 blank  output  4  bit i-1 set means digit i was blank in the published frame.
REQ-009 frame_valid  output  1  one-cycle pulse when a complete frame is published.
REQ-010 seg_err  output  1  sticky error flag; cleared on the next publish that has no error.
REQ-011 idle  output  1  high while no anode has been active for at least TIMEOUT_CYC cycles.

Function
REQ-012 The block SHALL register led_seg and a1-a4 once per clk and decode only the registered copies.
REQ-013 Decode table SHALL be as follows; any other pattern is invalid:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- blank=1111111
REQ-014 A sample is active when exactly one anode is low; two or more anodes low is a collision, which sets seg_err, resets the stability counter, and accepts nothing.
REQ-015 A stability counter SHALL increment while anode and segment samples equal the previous sample, and SHALL reload to 1 on any change.
REQ-016 When the counter reaches STABLE_CYC on an active sample, the block SHALL write the decoded value into that position's shadow slot and set its seen bit, once per stable run; further stable cycles do not rewrite.
REQ-017 An invalid pattern reaching STABLE_CYC SHALL set seen for that position, store digit 0 with blank=0, and flag a pending error.
REQ-018 When all four seen bits are set, the block SHALL, in the following cycle, do all of the following:
- copy shadow values to dig1-4 and blank;
- pulse frame_valid;
- clear the seen bits;
- update seg_err from the pending error and collision flags (set if either is set, else clear), then clear those flags.
REQ-019 Re-acceptance of an already-seen position before frame completion SHALL overwrite its shadow slot; the newest value wins.
REQ-020 Publish latency SHALL be exactly one cycle after the fourth seen bit sets; a new acceptance in the publish cycle SHALL land in the next frame.
REQ-021 The idle counter SHALL be 16 bits, reset on any active sample, and saturate at TIMEOUT_CYC.
- idle asserts in the cycle the counter reaches TIMEOUT_CYC.
- idle deasserts on the first active sample.
- When idle asserts, the seen bits and pending flags SHALL be cleared, discarding the partial frame.
REQ-022 Outputs SHALL hold their last published values while idle is asserted.

Reset
REQ-023 Reset SHALL set the following, regardless of clk:
- dig1-4 = 0, blank = 4'b1111;
- frame_valid = 0, seg_err = 0, idle = 0;
- seen, pending flags, and counters = 0;
- sample registers = all-ones (no anode, blank).
REQ-024 Reset mid-frame SHALL discard all partial shadow data, and the first post-reset frame SHALL need all four positions re-accepted.

Verification
REQ-025 Scan 0,1,0,0 with 4 cycles per anode in order a1→a4 -> frame_valid pulses once per scan; dig={0,1,0,0}, blank=0000, seg_err=0.
REQ-026 Scan 5,9,blank,7 with STABLE_CYC=2 and 1 cycle per anode -> no acceptance and no frame_valid; then 2 cycles per anode -> dig1=5, dig2=9, dig4=7, blank=0100.
REQ-027 Drive a1 and a3 low together for 3 cycles, then a valid 4-digit scan -> the first publish has seg_err=1; the next clean scan clears seg_err to 0.
REQ-028 Drive all anodes high for 1024 cycles after a partial 2-digit scan -> idle=1 at cycle 1024 and outputs unchanged; the partial frame is discarded, and resumed scanning produces the next frame only after all four positions are accepted.
REQ-029 Assert rst for 1 cycle mid-scan after 3 accepted digits -> outputs go to the reset values immediately; no frame_valid until 4 fresh acceptances.
REQ-030 Drive pattern 1010101 stable on a2 within a scan of 1,2,3,4 -> the publish shows dig2=0, blank=0000, seg_err=1.
